// File: rtl/cfg_pkg.sv
// Types and helpers shared by the column config receivers and the Wishbone config master.
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    localparam int CFG_COL_SEL_W = 4;

    function automatic int cfg_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-in/parallel-out shift register with synchronous clear; new bits enter at bit 0.
module cfg_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[W-2:0], din};
        end
    end

endmodule

// File: rtl/cfg_col_receiver.sv
// Column-side endpoint of the serial fabric-config stream: frames, deserialises and commits MY tile configs.
// Optional feature macro CFG_RX_SHADOW_EN: double-buffers the loading frame so cfg_out changes only on commit.
module cfg_col_receiver
    import cfg_pkg::*;
#(
    parameter int TILE_CFG_SIZE = 256,
    parameter int MY            = 4,
    parameter int COL_ID        = 0,
    parameter int COL_SEL_W     = CFG_COL_SEL_W
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [COL_SEL_W-1:0]        col_sel,
    input  logic                        cfg_in_start,
    input  logic                        cfg_bit_in,
    input  logic                        cfg_bit_in_valid,
    output logic [MY*TILE_CFG_SIZE-1:0] cfg_out,
    output logic                        cfg_busy,
    output logic                        cfg_done,
    output logic                        cfg_err
);

    localparam int N  = MY * TILE_CFG_SIZE;
    localparam int CW = cfg_cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    cfg_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          sel, accept, last_bit, clr;
    logic [N-1:0]  shift_q;

    assign sel      = (col_sel == COL_SEL_W'(COL_ID));
    // A bit arriving alongside a start pulse belongs to no frame and is dropped.
    assign accept   = (state_q == SHIFT) && sel && cfg_bit_in_valid && !cfg_in_start;
    assign last_bit = accept && (cnt_q == LAST);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (sel && cfg_in_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (sel && cfg_in_start) begin
                    cnt_d = '0;
                    err_d = 1'b1;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = COMMIT;
                        err_d   = 1'b0;
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    cfg_shift_reg #(.W(N)) u_shift (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr   (clr),
        .en    (accept),
        .din   (cfg_bit_in),
        .q     (shift_q)
    );

`ifdef CFG_RX_SHADOW_EN
    logic [N-1:0] active_q;
    logic         unused_shift_msb;

    assign unused_shift_msb = shift_q[N-1];
    assign clr              = sel && cfg_in_start;

    // Load the completed frame on the edge that enters COMMIT so cfg_out and cfg_done move together.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            active_q <= '0;
        end else if (last_bit) begin
            active_q <= {shift_q[N-2:0], cfg_bit_in};
        end
    end

    assign cfg_out = active_q;
`else
    logic unused_last_bit;

    assign unused_last_bit = last_bit;
    assign clr             = 1'b0;
    assign cfg_out         = shift_q;
`endif

    assign cfg_busy = (state_q == SHIFT);
    assign cfg_done = (state_q == COMMIT);
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_cfg_col_receiver.sv
// Self-checking bench for cfg_col_receiver (TILE_CFG_SIZE=8, MY=2, COL_ID=3): table, directed and random phases.
module tb_cfg_col_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_sel;
    logic        start, valid, bit_in;
    logic [15:0] cfg_out;
    logic        busy, done, err;

    int n_chk  = 0;
    int n_pass = 0;
    int done_seen = 0;

    // Reference model: frame-level bookkeeping (bits collected so far, pending commit).
    bit          m_loading;
    int          m_nbits;
    bit          m_commit;
    bit          m_err;
    logic [15:0] m_frame;
    logic [15:0] m_committed;
    logic [15:0] m_live;

    always #5 clk = ~clk;

    cfg_col_receiver #(
        .TILE_CFG_SIZE (8),
        .MY            (2),
        .COL_ID        (3),
        .COL_SEL_W     (4)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_ni        (rst_n),
        .col_sel          (col_sel),
        .cfg_in_start     (start),
        .cfg_bit_in       (bit_in),
        .cfg_bit_in_valid (valid),
        .cfg_out          (cfg_out),
        .cfg_busy         (busy),
        .cfg_done         (done),
        .cfg_err          (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] model_out();
`ifdef CFG_RX_SHADOW_EN
        return m_committed;
`else
        return m_live;
`endif
    endfunction

    task automatic model_update(input logic rn, input logic [3:0] cs, input logic st,
                                input logic v, input logic b);
        bit was_commit;
        bit s;
        s = (cs == 4'd3);
        if (!rn) begin
            m_loading = 0; m_nbits = 0; m_commit = 0; m_err = 0;
            m_frame = '0; m_committed = '0; m_live = '0;
            return;
        end
        was_commit = m_commit;
        m_commit   = 0;
        if (was_commit) return;
        if (!m_loading) begin
            if (s && st) begin m_loading = 1; m_nbits = 0; end
        end else if (s && st) begin
            m_nbits = 0;
            m_err   = 1;
        end else if (s && v) begin
            m_frame = {m_frame[14:0], b};
            m_live  = {m_live[14:0], b};
            m_nbits++;
            if (m_nbits == 16) begin
                m_loading   = 0;
                m_commit    = 1;
                m_err       = 0;
                m_committed = m_frame;
            end
        end
    endtask

    task automatic step(input logic rn, input logic [3:0] cs, input logic st,
                        input logic v, input logic b);
        rst_n = rn; col_sel = cs; start = st; valid = v; bit_in = b;
        @(posedge clk);
        #1;
        model_update(rn, cs, st, v, b);
        if (done === 1'b1) done_seen++;
        check("cycle{busy,done,err,out}", {13'd0, busy, done, err, cfg_out},
              {13'd0, m_loading, m_commit, m_err, model_out()});
    endtask

    task automatic send_frame(input logic [3:0] cs, input logic [15:0] data);
        logic [15:0] m;
        step(1, cs, 1, 0, 0);
        for (int i = 15; i >= 0; i--) begin
            step(1, cs, 0, 1, data[i]);
`ifndef CFG_RX_SHADOW_EN
            if (cs == 4'd3) begin
                m = 16'((32'h1 << (16 - i)) - 1);
                check("track", {16'd0, cfg_out & m}, {16'd0, (data >> i) & m});
            end
`endif
        end
        step(1, cs, 0, 0, 0);
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] data;
        logic [15:0] exp_out;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int d0;
        vecs[0] = '{sel: 4'd2, data: 16'hA5C3, exp_out: 16'h0000, exp_done: 0};
        vecs[1] = '{sel: 4'd3, data: 16'hA5C3, exp_out: 16'hA5C3, exp_done: 1};
        vecs[2] = '{sel: 4'd2, data: 16'h5555, exp_out: 16'hA5C3, exp_done: 0};
        vecs[3] = '{sel: 4'd3, data: 16'h0F0F, exp_out: 16'h0F0F, exp_done: 1};
        vecs[4] = '{sel: 4'd3, data: 16'h8001, exp_out: 16'h8001, exp_done: 1};

        m_loading = 0; m_nbits = 0; m_commit = 0; m_err = 0;
        m_frame = '0; m_committed = '0; m_live = '0;
        rst_n = 0; col_sel = 0; start = 0; valid = 0; bit_in = 0;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("reset_out",  {16'd0, cfg_out}, 32'd0);
        check("reset_ctl",  {29'd0, busy, done, err}, 32'd0);

        // Valid bits in IDLE must be ignored.
        for (int i = 0; i < 4; i++) step(1, 3, 0, 1, 1);
        check("idle_ignore", {16'd0, cfg_out}, 32'd0);

        for (int r = 0; r < 5; r++) begin
            d0 = done_seen;
            send_frame(vecs[r].sel, vecs[r].data);
            check($sformatf("vec%0d_out", r), {16'd0, cfg_out}, {16'd0, vecs[r].exp_out});
            check($sformatf("vec%0d_done", r), done_seen - d0, vecs[r].exp_done);
            check($sformatf("vec%0d_err", r), {31'd0, err}, 32'd0);
            if (r == 1) begin
                check("tile1", {24'd0, cfg_out[15:8]}, 32'hA5);
                check("tile0", {24'd0, cfg_out[7:0]},  32'hC3);
            end
        end

        // Restart mid-frame.
        d0 = done_seen;
        step(1, 3, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 3, 0, 1, 0);
        step(1, 3, 1, 0, 0);
        check("restart_err", {31'd0, err}, 32'd1);
        check("restart_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 16; i++) step(1, 3, 0, 1, 1);
        check("restart_done_edge", {31'd0, done}, 32'd1);
        step(1, 3, 0, 0, 0);
        check("restart_out", {16'd0, cfg_out}, 32'hFFFF);
        check("restart_err_clr", {31'd0, err}, 32'd0);
        check("restart_done_cnt", done_seen - d0, 1);

        // Gaps and deselect.
        d0 = done_seen;
        step(1, 3, 1, 0, 0);
        for (int i = 15; i >= 0; i--) begin
            step(1, 3, 0, 1, 16'h1234 >> i);
            if (i == 8) for (int k = 0; k < 4; k++) step(1, 7, 0, 1, 1);
            if (i > 0)  for (int k = 0; k < 3; k++) step(1, 3, 0, 0, 1);
        end
        step(1, 3, 0, 0, 0);
        check("gap_out", {16'd0, cfg_out}, 32'h1234);
        check("gap_done_cnt", done_seen - d0, 1);

        // Bit presented with the start pulse is dropped.
        step(1, 3, 1, 1, 1);
        for (int i = 0; i < 16; i++) step(1, 3, 0, 1, 0);
        step(1, 3, 0, 0, 0);
        check("startbit_out", {16'd0, cfg_out}, 32'h0000);

        // Reset mid-frame after an error.
        step(1, 3, 1, 0, 0);
        step(1, 3, 0, 1, 1);
        step(1, 3, 0, 1, 1);
        step(1, 3, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 3, 0, 1, 1);
        step(0, 3, 0, 0, 0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_out",  {16'd0, cfg_out}, 32'd0);
        check("rst_mid_err",  {31'd0, err}, 32'd0);
        d0 = done_seen;
        send_frame(3, 16'hBEEF);
        check("beef_out", {16'd0, cfg_out}, 32'hBEEF);
        check("beef_done_cnt", done_seen - d0, 1);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] cs;
            cs = ($urandom_range(0, 9) < 8) ? 4'd3 : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 499) != 0),
                 cs,
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
